// File: rtl/mux_nt1_rr_reg.sv
// ============================================================================
// Module      : mux_nt1_rr_reg
// Description : N-to-1 registered mux with per-channel valid/ready, selected
//               either by a fixed sel index or by round-robin arbitration.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mux_nt1_rr_reg #(
    parameter  int WIDTH = 32,
    parameter  int N     = 8,
    localparam int SELW  = $clog2(N)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N*WIDTH-1:0]   in_data_i,
    input  logic [N-1:0]         in_valid_i,
    output logic [N-1:0]         in_ready_o,
    input  logic                 mode_i,
    input  logic [SELW-1:0]      sel_i,
    output logic [WIDTH-1:0]     out_data_o,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [SELW-1:0]      out_src_o
);

    localparam int SUMW = SELW + 1;

    logic [WIDTH-1:0] data_q,   data_d;
    logic [SELW-1:0]  src_q,    src_d;
    logic             valid_q,  valid_d;
    logic [SELW-1:0]  rr_ptr_q, rr_ptr_d;

    logic             load_en;
    logic             grant_vld;
    logic [SELW-1:0]  grant_idx;
    logic [SUMW-1:0]  rr_scan;
    logic [WIDTH-1:0] grant_data;

    assign load_en = ~valid_q | out_ready_i;

    // Round-robin scans from the highest offset down so the channel nearest
    // rr_ptr is the one left standing; the scan index wraps modulo N.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        rr_scan   = '0;
        if (!mode_i) begin
            if (int'(sel_i) < N) begin
                if (in_valid_i[sel_i]) begin
                    grant_vld = 1'b1;
                    grant_idx = sel_i;
                end
            end
        end else begin
            for (int k = N - 1; k >= 0; k--) begin
                rr_scan = {1'b0, rr_ptr_q} + SUMW'(k);
                if (rr_scan >= SUMW'(N)) begin
                    rr_scan = rr_scan - SUMW'(N);
                end
                if (in_valid_i[rr_scan[SELW-1:0]]) begin
                    grant_vld = 1'b1;
                    grant_idx = rr_scan[SELW-1:0];
                end
            end
        end
    end

    always_comb begin
        grant_data = '0;
        for (int i = 0; i < N; i++) begin
            if (grant_idx == SELW'(i)) begin
                grant_data = in_data_i[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        in_ready_o = '0;
        if (load_en && grant_vld && !rst) begin
            in_ready_o[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        data_d   = data_q;
        src_d    = src_q;
        valid_d  = valid_q;
        rr_ptr_d = rr_ptr_q;
        if (load_en) begin
            valid_d = grant_vld;
            if (grant_vld) begin
                data_d = grant_data;
                src_d  = grant_idx;
                if (mode_i) begin
                    rr_ptr_d = (grant_idx == SELW'(N - 1)) ? '0 : grant_idx + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q   <= '0;
            src_q    <= '0;
            valid_q  <= 1'b0;
            rr_ptr_q <= '0;
        end else begin
            data_q   <= data_d;
            src_q    <= src_d;
            valid_q  <= valid_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign out_data_o  = data_q;
    assign out_src_o   = src_q;
    assign out_valid_o = valid_q;

endmodule

`default_nettype wire

// File: tb/tb_mux_nt1_rr_reg.sv
// ============================================================================
// Module      : tb_mux_nt1_rr_reg
// Description : Directed scoreboard bench for mux_nt1_rr_reg (N=8 and N=5).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mux_nt1_rr_reg;

    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst;
    logic [8*W-1:0] in_data;
    logic [7:0]     in_valid;
    logic [7:0]     in_ready;
    logic           mode;
    logic [2:0]     sel;
    logic [W-1:0]   out_data;
    logic           out_valid;
    logic           out_ready;
    logic [2:0]     out_src;

    logic [5*W-1:0] in_data5;
    logic [4:0]     in_valid5;
    logic [4:0]     in_ready5;
    logic           mode5;
    logic [2:0]     sel5;
    logic [W-1:0]   out_data5;
    logic           out_valid5;
    logic           out_ready5 = 1'b1;
    logic [2:0]     out_src5;

    int          nvec = 0;
    int          nerr = 0;
    logic [34:0] sbq[$];
    logic [34:0] sb_exp;
    logic [31:0] chdat[8];
    logic [31:0] chdat5[5];

    always #5 clk = ~clk;

    mux_nt1_rr_reg #(.WIDTH(W), .N(8)) u_dut (
        .clk(clk), .rst(rst), .in_data_i(in_data), .in_valid_i(in_valid),
        .in_ready_o(in_ready), .mode_i(mode), .sel_i(sel), .out_data_o(out_data),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .out_src_o(out_src)
    );

    mux_nt1_rr_reg #(.WIDTH(W), .N(5)) u_dut5 (
        .clk(clk), .rst(rst), .in_data_i(in_data5), .in_valid_i(in_valid5),
        .in_ready_o(in_ready5), .mode_i(mode5), .sel_i(sel5), .out_data_o(out_data5),
        .out_valid_o(out_valid5), .out_ready_i(out_ready5), .out_src_o(out_src5)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int oh2idx(input logic [7:0] v);
        int r = 0;
        for (int i = 0; i < 8; i++) begin
            if (v[i]) r = i;
        end
        return r;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    // Apply one cycle of stimulus, check in_ready, queue the word expected out.
    task automatic drive(input logic m, input logic [2:0] s, input logic [7:0] v,
                         input logic ordy, input logic [7:0] exp_rdy, input string name);
        mode      = m;
        sel       = s;
        in_valid  = v;
        out_ready = ordy;
        #1;
        check(name, {56'b0, in_ready}, {56'b0, exp_rdy});
        if (exp_rdy != 8'h00) begin
            int g;
            g = oh2idx(exp_rdy);
            sbq.push_back({3'(g), chdat[g]});
        end
        cyc();
    endtask

    task automatic drive5(input logic m, input logic [2:0] s, input logic [4:0] v,
                          input logic [4:0] exp_rdy, input string name);
        mode5     = m;
        sel5      = s;
        in_valid5 = v;
        #1;
        check(name, {59'b0, in_ready5}, {59'b0, exp_rdy});
        cyc();
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sbq.size() == 0) begin
                nvec++;
                nerr++;
                $display("FAIL sb_unexpected: got src %0d data %h expected no word", out_src, out_data);
            end else begin
                sb_exp = sbq.pop_front();
                check("sb_word", {29'b0, out_src, out_data}, {29'b0, sb_exp});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 8; i++) chdat[i] = 32'hA5A5_0000 + 32'(i);
        chdat[5] = 32'hDEADBEEF;
        for (int i = 0; i < 5; i++) chdat5[i] = 32'h5500_0010 + 32'(i);
        for (int i = 0; i < 8; i++) in_data[i*W +: W] = chdat[i];
        for (int i = 0; i < 5; i++) in_data5[i*W +: W] = chdat5[i];

        rst = 1'b1; mode = 1'b0; sel = 3'd0; in_valid = 8'h00; out_ready = 1'b0;
        mode5 = 1'b0; sel5 = 3'd0; in_valid5 = 5'h00;
        cyc();
        cyc();
        check("rst_out_valid", {63'b0, out_valid}, 64'd0);
        check("rst_out_data", {32'b0, out_data}, 64'd0);
        check("rst_out_src", {61'b0, out_src}, 64'd0);
        rst = 1'b0;

        // fixed select of channel 5
        drive(1'b0, 3'd5, 8'h20, 1'b1, 8'h20, "t1_ready");
        check("t1_out_valid", {63'b0, out_valid}, 64'd1);
        drive(1'b0, 3'd5, 8'h00, 1'b1, 8'h00, "t1_idle");

        // round-robin with all channels valid: 0..7 twice
        for (int k = 0; k < 16; k++) begin
            drive(1'b1, 3'd0, 8'hFF, 1'b1, 8'(1 << (k % 8)), "t2_rr_ready");
        end
        drive(1'b1, 3'd0, 8'h00, 1'b1, 8'h00, "t2_idle");

        // wrap 7 -> 0 -> 7 with ptr parked at 7
        drive(1'b1, 3'd0, 8'h40, 1'b1, 8'h40, "t3_set_ptr");
        drive(1'b1, 3'd0, 8'h81, 1'b1, 8'h80, "t3_g7");
        drive(1'b1, 3'd0, 8'h81, 1'b1, 8'h01, "t3_g0");
        drive(1'b1, 3'd0, 8'h81, 1'b1, 8'h80, "t3_g7b");
        drive(1'b1, 3'd0, 8'h00, 1'b1, 8'h00, "t3_idle");

        // backpressure for three cycles, then drain and load together
        drive(1'b0, 3'd2, 8'h04, 1'b1, 8'h04, "t4_load");
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 3'd3, 8'h08, 1'b0, 8'h00, "t4_stall_ready");
            check("t4_stall_valid", {63'b0, out_valid}, 64'd1);
            check("t4_stall_src", {61'b0, out_src}, 64'd2);
            check("t4_stall_data", {32'b0, out_data}, {32'b0, chdat[2]});
        end
        drive(1'b0, 3'd3, 8'h08, 1'b1, 8'h08, "t4_drain_load");
        check("t4_new_src", {61'b0, out_src}, 64'd3);
        check("t4_new_valid", {63'b0, out_valid}, 64'd1);
        drive(1'b0, 3'd3, 8'h00, 1'b1, 8'h00, "t4_idle");

        // selected channel not valid: no grant, outputs hold
        drive(1'b0, 3'd6, 8'h01, 1'b1, 8'h00, "t5_ready");
        check("t5_out_valid", {63'b0, out_valid}, 64'd0);
        check("t5_src_hold", {61'b0, out_src}, 64'd3);
        check("t5_data_hold", {32'b0, out_data}, {32'b0, chdat[3]});

        // reset while holding a word, with every channel requesting
        drive(1'b1, 3'd0, 8'hFF, 1'b1, 8'h01, "t6_preload");
        check("t6_pre_valid", {63'b0, out_valid}, 64'd1);
        rst = 1'b1;
        sbq.delete();
        drive(1'b1, 3'd0, 8'hFF, 1'b1, 8'h00, "t6_rst_ready");
        check("t6_out_valid", {63'b0, out_valid}, 64'd0);
        check("t6_out_data", {32'b0, out_data}, 64'd0);
        check("t6_out_src", {61'b0, out_src}, 64'd0);
        rst = 1'b0;
        drive(1'b1, 3'd0, 8'hFF, 1'b1, 8'h01, "t6_first_rr");
        drive(1'b1, 3'd0, 8'h00, 1'b1, 8'h00, "t6_idle");

        // N=5: wrap 4 -> 0 -> 4
        drive5(1'b1, 3'd0, 5'h08, 5'h08, "n5_set_ptr");
        check("n5_src3", {61'b0, out_src5}, 64'd3);
        drive5(1'b1, 3'd0, 5'h11, 5'h10, "n5_g4");
        check("n5_src4", {61'b0, out_src5}, 64'd4);
        check("n5_data4", {32'b0, out_data5}, {32'b0, chdat5[4]});
        drive5(1'b1, 3'd0, 5'h11, 5'h01, "n5_g0");
        check("n5_src0", {61'b0, out_src5}, 64'd0);
        drive5(1'b1, 3'd0, 5'h11, 5'h10, "n5_g4b");
        check("n5_src4b", {61'b0, out_src5}, 64'd4);

        // N=5: sel beyond the last channel never grants
        drive5(1'b0, 3'd7, 5'h1F, 5'h00, "n5_sel7");
        check("n5_sel7_valid", {63'b0, out_valid5}, 64'd0);
        drive5(1'b0, 3'd7, 5'h1F, 5'h00, "n5_sel7b");
        drive5(1'b0, 3'd4, 5'h1F, 5'h10, "n5_sel4");
        check("n5_sel4_src", {61'b0, out_src5}, 64'd4);
        check("n5_sel4_valid", {63'b0, out_valid5}, 64'd1);
        in_valid5 = 5'h00;

        cyc();
        check("sb_drain", 64'(sbq.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

`default_nettype wire
